// File: rtl/vga_fb_pkg.sv
// Shared constants, types and helpers for the VGA framebuffer scanout stage.
// Framebuffer geometry, RGB332 field layout, swap FSM encoding and the
// sync/active bundle that travels down the display delay line.
package vga_fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 15;
    localparam int PIX_W    = 8;

    // RGB332 field positions inside a stored pixel byte
    localparam int RED_MSB = 7;
    localparam int RED_LSB = 5;
    localparam int GRN_MSB = 4;
    localparam int GRN_LSB = 2;
    localparam int BLU_MSB = 1;
    localparam int BLU_LSB = 0;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // Timing-generator side-band that must stay aligned with the pixel data
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    // Replicate the top bits of each field so full-scale codes map to 0xF
    function automatic rgb444_t expand_rgb332(input logic [PIX_W-1:0] p);
        rgb444_t c;
        c.red   = {p[RED_MSB:RED_LSB], p[RED_MSB]};
        c.green = {p[GRN_MSB:GRN_LSB], p[GRN_MSB]};
        c.blue  = {p[BLU_MSB:BLU_LSB], p[BLU_MSB:BLU_LSB]};
        return c;
    endfunction

    // Linear pixel address row*FB_W+col; 160 = 128+32 so no multiplier is needed
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_AW-1:0] row,
                                                 input logic [FB_AW-1:0] col);
        if (FB_W == 160)
            return (row << 7) + (row << 5) + col;
        else
            return FB_AW'(row * FB_AW'(FB_W)) + col;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Contents are deliberately not reset so the array maps onto block RAM.
// A read and write to the same address in one clock returns the old data.
module fb_dpram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // registered read port, holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_framebuffer.sv
// VGA scanout stage: fetches 4x-upscaled RGB332 pixels from an on-chip
// 160x120 framebuffer and drives RGB444 plus syncs, 2 pixel strobes behind
// the timing generator. CPU write port fills the back buffer.
// Build option VGA_FB_DOUBLE_BUFFER_EN: two banks with a tear-free swap
// committed on the animate tick; without it a single bank is displayed and
// written directly.
module vga_framebuffer
    import vga_fb_pkg::*;
#(
    parameter int SCALE_SHIFT = 2
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_pixel_stb,
    input  logic [9:0]       in_x,
    input  logic [8:0]       in_y,
    input  logic             in_Hsync,
    input  logic             in_Vsync,
    input  logic             in_active,
    input  logic             in_animate,
    input  logic             in_wr_valid,
    input  logic [FB_AW-1:0] in_wr_addr,
    input  logic [PIX_W-1:0] in_wr_data,
    output logic             out_wr_ready,
    input  logic             in_swap_req,
    output logic             out_swap_done,
    output logic             out_Hsync,
    output logic             out_Vsync,
    output logic [3:0]       out_red,
    output logic [3:0]       out_green,
    output logic [3:0]       out_blue
);

    localparam int DLY = 2;

    logic [FB_AW-1:0] rd_addr;
    logic             rd_en;
    logic [PIX_W-1:0] rd_data;
    logic             wr_fire;
    ctl_t             ctl_in;
    ctl_t [DLY:1]     ctl_q;
    rgb444_t          rgb_next;
    rgb444_t          rgb_q;

    assign rd_addr = fb_addr(FB_AW'(in_y >> SCALE_SHIFT), FB_AW'(in_x >> SCALE_SHIFT));
    assign rd_en   = in_pixel_stb;
    assign ctl_in  = '{hsync: in_Hsync, vsync: in_Vsync, active: in_active};

    // out-of-range addresses are handshaken but never reach the RAM
    assign wr_fire = in_wr_valid & out_wr_ready & (in_wr_addr < FB_AW'(FB_DEPTH));

`ifdef VGA_FB_DOUBLE_BUFFER_EN

    swap_state_t      state;
    logic             front;
    logic             rd_bank;
    logic             swap_done_q;
    logic [1:0]       bank_we;
    logic [PIX_W-1:0] bank_q [2];

    // writes are stalled while a swap is waiting so the back buffer can't tear
    assign out_wr_ready  = (state == SWAP_IDLE);
    assign out_swap_done = swap_done_q;

    // swap FSM: a request waits for the end of the last active line, then flips banks
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state       <= SWAP_IDLE;
            front       <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            case (state)
                SWAP_IDLE: begin
                    if (in_swap_req) state <= SWAP_PENDING;
                end
                SWAP_PENDING: begin
                    if (in_pixel_stb && in_animate) begin
                        state       <= SWAP_IDLE;
                        front       <= ~front;
                        swap_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // remember which bank the in-flight read came from
    always_ff @(posedge in_clock) begin
        if (in_reset)          rd_bank <= 1'b0;
        else if (in_pixel_stb) rd_bank <= front;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = wr_fire & (front != 1'(b));

        fb_dpram #(
            .DEPTH (FB_DEPTH),
            .AW    (FB_AW),
            .DW    (PIX_W)
        ) u_ram (
            .clk   (in_clock),
            .we    (bank_we[b]),
            .waddr (in_wr_addr),
            .wdata (in_wr_data),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (bank_q[b])
        );
    end

    assign rd_data = bank_q[rd_bank];

`else

    logic unused_swap;

    assign out_wr_ready  = 1'b1;
    assign out_swap_done = 1'b0;
    assign unused_swap   = ^{in_swap_req, in_animate};

    fb_dpram #(
        .DEPTH (FB_DEPTH),
        .AW    (FB_AW),
        .DW    (PIX_W)
    ) u_ram (
        .clk   (in_clock),
        .we    (wr_fire),
        .waddr (in_wr_addr),
        .wdata (in_wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`endif

    assign rgb_next = ctl_q[1].active ? expand_rgb332(rd_data) : '0;

    // display pipeline: side-band shift register and colour register advance on strobes
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            ctl_q <= {DLY{CTL_RESET}};
            rgb_q <= '0;
        end else if (in_pixel_stb) begin
            ctl_q <= {ctl_q[DLY-1:1], ctl_in};
            rgb_q <= rgb_next;
        end
    end

    assign out_Hsync = ctl_q[DLY].hsync;
    assign out_Vsync = ctl_q[DLY].vsync;
    assign out_red   = rgb_q.red;
    assign out_green = rgb_q.green;
    assign out_blue  = rgb_q.blue;

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Scanout stage directly downstream of the 640x480 VGA timing generator. Consumes its pixel coordinates, sync and active flags, and fetches pixels from an on-chip 160x120 RGB332 framebuffer upscaled 4x. Drives 4-bit-per-channel RGB plus sync, re-aligned to the fetch latency. Exposes a CPU-side write port and a tear-free double-buffer swap committed at the end of the last active line.

## Interface
- SCALE_SHIFT, 2, log2 of the upscale factor; framebuffer coordinate = screen coordinate >> SCALE_SHIFT
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- in_clock  input  1  system clock; the only clock
- in_reset  input  1  synchronous, active-high reset
- in_pixel_stb  input  1  pixel-rate enable; the whole display pipeline advances only when high
- in_x  input  10  active pixel column from the timing generator
- in_y  input  9  active pixel row from the timing generator
- in_Hsync, in_Vsync  input  1  active-low syncs from the timing generator
- in_active  input  1  high while the current pixel is visible
- in_animate  input  1  end-of-last-active-line tick
- in_wr_valid  input  1  CPU write request
- in_wr_addr  input  15  linear pixel address, y*FB_W+x
- in_wr_data  input  8  RGB332 pixel value
- out_wr_ready  output  1  write accepted on a cycle with in_wr_valid & out_wr_ready
- in_swap_req  input  1  single-cycle request to present the back buffer
- out_swap_done  output  1  one-cycle pulse when the swap is committed
- out_Hsync, out_Vsync  output  1  delayed syncs
- out_red, out_green, out_blue  output  4 each  pixel colour; 0 when not active

## Operation
- Read address = (in_y>>SCALE_SHIFT)*FB_W + (in_x>>SCALE_SHIFT), computed combinationally.
  - For FB_W=160, use shift-add: (y<<7)+(y<<5).
  - Maximum address 19199.
- Two banks, each FB_W*FB_H bytes. Register `front` selects the displayed bank; writes target bank ~front.
- Colour expansion:
  - red = {p[7:5],p[7]}
  - green = {p[4:2],p[4]}
  - blue = {p[1:0],p[1:0]}
  - Colour is forced to 0 when the delayed active flag is low.
- Writes:
  - Accepted when in_wr_valid & out_wr_ready.
  - Addresses ≥ FB_W*FB_H are accepted and discarded.
  - out_wr_ready = ~swap_pending.
- Swap state machine, states IDLE and PENDING:
  - IDLE→PENDING on in_swap_req.
  - PENDING→IDLE on in_pixel_stb & in_animate. On that cycle `front` toggles and out_swap_done pulses on the next cycle.
  - in_swap_req while in PENDING merges with the pending request; no second swap occurs.
- Reset values:
  - front=0, state IDLE
  - out_Hsync=1, out_Vsync=1
  - RGB=0, out_swap_done=0
  - delay line filled with Hsync=1, Vsync=1, active=0
  - RAM contents are not reset
- Reset mid-frame or mid-pending discards the pending swap.

## Timing
- Display latency is exactly 2 pixel strobes.
  - Strobe N: RAM read issued with address and bank.
  - Strobe N+1: data is registered through colour expansion into the output registers, together with Hsync, Vsync and active, which were delayed by a 2-deep shift register clocked on strobes.
- Outputs hold between strobes.
- RAM write takes effect 1 clock after acceptance. A read of the same address in the same clock returns old data (single-bank build only).
- Swap request arriving on the same clock as the animate strobe from IDLE is registered; the swap commits on the next frame's animate.
- out_swap_done is high for exactly 1 clock.

## Configuration
- VGA_FB_DOUBLE_BUFFER_EN defined: two banks and swap logic as above.
- VGA_FB_DOUBLE_BUFFER_EN undefined:
  - a single bank is instantiated, and writes go to the displayed bank
  - in_swap_req is ignored, out_swap_done is tied to 0, out_wr_ready is tied to 1
  - display behaviour and latency are unchanged

## Structure
- Package vga_fb_pkg holds:
  - FB_W, FB_H, FB_DEPTH (=FB_W*FB_H), FB_AW (15)
  - RGB332 field positions
  - the swap state encoding
- Sub-module fb_dpram: simple dual-port RAM with one write port, one registered read port and read enable, inferred as block RAM. Instantiated once per bank.

## Test plan
- Reset, then free-running timing: out_Hsync and out_Vsync are 1 and RGB is 0 until the first delayed values emerge 2 strobes later.
- Write 0xE0 to address 0, swap, then wait for the animate tick: screen pixels (0..3, 0..3) show red=F, green=0, blue=0; pixel (4,0) shows the back-buffer default.
- Write 0x1C at address 19199: visible at screen pixel (636..639, 476..479) as green=F; a write to 19200 leaves all pixels unchanged.
- in_swap_req raised mid-frame:
  - out_wr_ready drops the next cycle
  - front toggles on animate, out_swap_done pulses once, out_wr_ready returns to 1
  - a second request while pending gives only one swap
- in_reset asserted while PENDING: no swap occurs and front=0.
- Blanking region with in_active=0: RGB=0 regardless of RAM contents; sync edges appear exactly 2 strobes after the input edges.
